// File: rtl/noc_input_port_rx.sv
// Router input port: RTS/DCTS link receiver, flit FIFO and XY route decode
// producing a held one-hot request toward the five output arbiters.
module noc_input_port_rx #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int COORD_W    = 4,
    parameter int CUR_X      = 0,
    parameter int CUR_Y      = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RTS,
    output logic                  DCTS,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  grant_n,
    input  logic                  grant_e,
    input  logic                  grant_w,
    input  logic                  grant_s,
    input  logic                  grant_l,
    output logic                  req_n,
    output logic                  req_e,
    output logic                  req_w,
    output logic                  req_s,
    output logic                  req_l,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  empty,
    output logic                  full,
    output logic                  err_flit
);

    // state  | meaning
    // IDLE   | waiting for a header flit at the FIFO head
    // ROUTED | request held until the tail flit is popped
    typedef enum logic {IDLE, ROUTED} state_t;

    localparam int             PW      = $clog2(DEPTH);
    localparam logic [PW:0]    DEPTH_C = (PW+1)'(DEPTH);
    localparam logic [2:0]     T_HEAD  = 3'b001;
    localparam logic [2:0]     T_TAIL  = 3'b100;
    localparam logic [COORD_W-1:0] CX  = COORD_W'(CUR_X);
    localparam logic [COORD_W-1:0] CY  = COORD_W'(CUR_Y);

    // request vector bit order: {n, e, w, s, l}
    localparam logic [4:0] R_N = 5'b10000;
    localparam logic [4:0] R_E = 5'b01000;
    localparam logic [4:0] R_W = 5'b00100;
    localparam logic [4:0] R_S = 5'b00010;
    localparam logic [4:0] R_L = 5'b00001;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [PW:0]           count_q;
    logic                  dcts_q;
    logic [4:0]            req_q, req_d;
    logic                  err_q, err_d;
    state_t                state_q, state_d;

    logic                  push, pop, grant_any, grant_pop, err_pop;
    logic [2:0]            head_type;
    logic [COORD_W-1:0]    dx, dy;

    assign empty     = (count_q == '0);
    assign full      = (count_q == DEPTH_C);
    assign head_data = empty ? '0 : mem_q[rd_ptr_q];
    assign head_type = head_data[DATA_WIDTH-1 -: 3];
    assign dx        = head_data[DATA_WIDTH-4 -: COORD_W];
    assign dy        = head_data[DATA_WIDTH-4-COORD_W -: COORD_W];

    assign grant_any = grant_n | grant_e | grant_w | grant_s | grant_l;
    assign grant_pop = grant_any & ~empty;
    // stray body/tail flits at the head while idle are dropped here
    assign err_pop   = (state_q == IDLE) & ~empty & (head_type != T_HEAD);
    assign pop       = grant_pop | err_pop;
    assign push      = RTS & dcts_q;

    assign DCTS     = dcts_q;
    assign req_n    = req_q[4];
    assign req_e    = req_q[3];
    assign req_w    = req_q[2];
    assign req_s    = req_q[1];
    assign req_l    = req_q[0];
    assign err_flit = err_q;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    if (head_type == T_HEAD) begin
                        if (dx > CX)      req_d = R_E;
                        else if (dx < CX) req_d = R_W;
                        else if (dy < CY) req_d = R_N;
                        else if (dy > CY) req_d = R_S;
                        else              req_d = R_L;
                        state_d = ROUTED;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ROUTED: begin
                if (grant_pop && head_type == T_TAIL) begin
                    req_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dcts_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= IDLE;
            req_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            // slot is reserved at decision time, so a granted write never overflows
            dcts_q  <= RTS & ~dcts_q & (count_q < DEPTH_C);
            state_q <= state_d;
            req_q   <= req_d;
            err_q   <= err_d;
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (push && !pop)      count_q <= count_q + (PW+1)'(1);
            else if (pop && !push) count_q <= count_q - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= rx_data;
    end

endmodule

// File: tb/tb_noc_input_port_rx.sv
// Directed bench for noc_input_port_rx with a queue-based reference model
// compared every cycle, plus literal expectations per scenario.
module tb_noc_input_port_rx;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CX    = 1;
    localparam int CY    = 1;

    localparam logic [2:0] TH = 3'b001;
    localparam logic [2:0] TB = 3'b010;
    localparam logic [2:0] TT = 3'b100;

    localparam int PN = 0, PE = 1, PW_ = 2, PS = 3, PL = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          RTS = 1'b0;
    logic [DW-1:0] rx_data = '0;
    logic          grant_n = 1'b0, grant_e = 1'b0, grant_w = 1'b0, grant_s = 1'b0, grant_l = 1'b0;
    logic          DCTS, req_n, req_e, req_w, req_s, req_l, empty, full, err_flit;
    logic [DW-1:0] head_data;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    noc_input_port_rx #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .COORD_W(4), .CUR_X(CX), .CUR_Y(CY)
    ) dut (
        .clk(clk), .rst(rst), .RTS(RTS), .DCTS(DCTS), .rx_data(rx_data),
        .grant_n(grant_n), .grant_e(grant_e), .grant_w(grant_w),
        .grant_s(grant_s), .grant_l(grant_l),
        .req_n(req_n), .req_e(req_e), .req_w(req_w), .req_s(req_s), .req_l(req_l),
        .head_data(head_data), .empty(empty), .full(full), .err_flit(err_flit)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk(input logic [2:0] t, input logic [3:0] dx,
                                         input logic [3:0] dy, input logic [7:0] pl);
        return {t, dx, dy, 13'b0, pl};
    endfunction

    // reference routing: returns {n,e,w,s,l}
    function automatic logic [4:0] route(input logic [DW-1:0] f);
        int dx, dy;
        dx = int'(f[28:25]);
        dy = int'(f[24:21]);
        if (dx > CX) return 5'b01000;
        if (dx < CX) return 5'b00100;
        if (dy < CY) return 5'b10000;
        if (dy > CY) return 5'b00010;
        return 5'b00001;
    endfunction

    // reference model: flit queue, link state, route request, sticky error
    logic [DW-1:0] mq[$];
    bit            m_dcts = 0, m_err = 0, m_routed = 0;
    logic [4:0]    m_req = '0;
    bit            g_any, has, do_pop, m_push, m_nd;
    logic [DW-1:0] h;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_dcts = 0; m_req = '0; m_err = 0; m_routed = 0;
        end else begin
            g_any  = grant_n | grant_e | grant_w | grant_s | grant_l;
            has    = mq.size() > 0;
            h      = has ? mq[0] : '0;
            m_push = RTS && m_dcts;
            m_nd   = RTS && !m_dcts && (mq.size() < DEPTH);
            do_pop = has && g_any;
            if (!m_routed && has) begin
                if (h[31:29] == TH) begin
                    m_req = route(h);
                    m_routed = 1;
                end else begin
                    m_err = 1;
                    do_pop = 1;
                end
            end else if (m_routed && do_pop && h[31:29] == TT) begin
                m_req = '0;
                m_routed = 0;
            end
            if (do_pop) void'(mq.pop_front());
            if (m_push) mq.push_back(rx_data);
            m_dcts = m_nd;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_dcts",  DCTS, m_dcts);
            chk("m_req",   {req_n, req_e, req_w, req_s, req_l}, m_req);
            chk("m_head",  head_data, (mq.size() > 0) ? mq[0] : '0);
            chk("m_empty", empty, mq.size() == 0);
            chk("m_full",  full, mq.size() == DEPTH);
            chk("m_err",   err_flit, m_err);
        end
    end

    task automatic send(input logic [DW-1:0] f);
        int n;
        rx_data = f;
        RTS = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!DCTS && n < 40);
        chk("send_dcts", DCTS, 1'b1);
        if (DCTS) @(posedge clk);
        #1 RTS = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic set_grant(input int p, input logic v);
        case (p)
            PN:      grant_n = v;
            PE:      grant_e = v;
            PW_:     grant_w = v;
            PS:      grant_s = v;
            default: grant_l = v;
        endcase
    endtask

    task automatic pulse(input int p);
        set_grant(p, 1'b1);
        @(posedge clk);
        #1 set_grant(p, 1'b0);
    endtask

    task automatic route_pkt(input logic [3:0] dx, input logic [3:0] dy,
                             input logic [4:0] exp, input int p);
        send(mk(TH, dx, dy, 8'h50));
        @(negedge clk);
        chk("route_req", {req_n, req_e, req_w, req_s, req_l}, exp);
        @(posedge clk); #1;
        send(mk(TT, 4'd0, 4'd0, 8'h5F));
        pulse(p);
        pulse(p);
        @(negedge clk);
        chk("route_req_clear", {req_n, req_e, req_w, req_s, req_l}, 5'b0);
        chk("route_empty", empty, 1'b1);
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        @(posedge clk); #1 cmp_en = 1'b1;
        @(posedge clk); #1 rst = 1'b0;

        // reset state and first handshake
        @(negedge clk);
        chk("t1_rst_dcts", DCTS, 1'b0);
        chk("t1_rst_empty", empty, 1'b1);
        chk("t1_rst_err", err_flit, 1'b0);
        @(posedge clk); #1;
        rx_data = mk(TH, 4'd2, 4'd1, 8'h11);
        RTS = 1'b1;
        @(negedge clk);
        chk("t1_dcts_t", DCTS, 1'b0);
        @(negedge clk);
        chk("t1_dcts_t1", DCTS, 1'b1);
        chk("t1_empty_t1", empty, 1'b1);
        @(posedge clk); #1 RTS = 1'b0;
        @(negedge clk);
        chk("t1_dcts_t2", DCTS, 1'b0);
        chk("t1_empty_t2", empty, 1'b0);
        chk("t1_head", head_data, 32'h2420_0011);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t3_req_e", {req_n, req_e, req_w, req_s, req_l}, 5'b01000);
        @(posedge clk); #1;

        // fill to full, then a blocked fifth flit released by one pop
        send(mk(TB, 4'd0, 4'd0, 8'h12));
        send(mk(TB, 4'd0, 4'd0, 8'h13));
        send(mk(TT, 4'd0, 4'd0, 8'h14));
        @(negedge clk);
        chk("t2_full", full, 1'b1);
        @(posedge clk); #1;
        fork
            send(mk(TH, 4'd1, 4'd0, 8'h21));
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("t2_hold", DCTS, 1'b0);
                end
                @(posedge clk); #1 grant_e = 1'b1;
                @(posedge clk); #1 grant_e = 1'b0;
                @(negedge clk);
                chk("t2_dcts_pop", DCTS, 1'b0);
                chk("t2_full_pop", full, 1'b0);
                @(negedge clk);
                chk("t2_dcts_next", DCTS, 1'b1);
            end
        join
        pulse(PE);
        pulse(PE);
        pulse(PE);
        @(negedge clk);
        chk("t3_tail_drop", {req_n, req_e, req_w, req_s, req_l}, 5'b0);
        chk("t3_next_head", head_data, 32'h2200_0021);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t3_req_n", {req_n, req_e, req_w, req_s, req_l}, 5'b10000);
        @(posedge clk); #1;
        send(mk(TT, 4'd0, 4'd0, 8'h22));
        pulse(PN);
        pulse(PN);

        // remaining route directions
        route_pkt(4'd1, 4'd1, 5'b00001, PL);
        route_pkt(4'd0, 4'd3, 5'b00100, PW_);
        route_pkt(4'd1, 4'd2, 5'b00010, PS);

        // four-flit packet popped back to back
        send(mk(TH, 4'd2, 4'd1, 8'h41));
        send(mk(TB, 4'd0, 4'd0, 8'h42));
        send(mk(TB, 4'd0, 4'd0, 8'h43));
        send(mk(TT, 4'd0, 4'd0, 8'h44));
        grant_e = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t4_req_held", {req_n, req_e, req_w, req_s, req_l}, 5'b01000);
        chk("t4_head_tail", head_data, 32'h8000_0044);
        @(posedge clk); #1 grant_e = 1'b0;
        @(negedge clk);
        chk("t4_req_drop", {req_n, req_e, req_w, req_s, req_l}, 5'b0);
        chk("t4_empty", empty, 1'b1);
        @(posedge clk); #1;

        // simultaneous push and pop at three entries
        send(mk(TH, 4'd3, 4'd1, 8'h51));
        send(mk(TB, 4'd0, 4'd0, 8'h52));
        send(mk(TB, 4'd0, 4'd0, 8'h53));
        fork
            send(mk(TT, 4'd0, 4'd0, 8'h54));
            begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!DCTS && n < 40);
                chk("t5_dcts", DCTS, 1'b1);
                grant_e = 1'b1;
                @(posedge clk); #1 grant_e = 1'b0;
            end
        join
        @(negedge clk);
        chk("t5_full", full, 1'b0);
        chk("t5_empty", empty, 1'b0);
        chk("t5_head1", head_data, 32'h4000_0052);
        @(posedge clk); #1;
        pulse(PE);
        @(negedge clk);
        chk("t5_head2", head_data, 32'h4000_0053);
        @(posedge clk); #1;
        pulse(PE);
        @(negedge clk);
        chk("t5_head3", head_data, 32'h8000_0054);
        @(posedge clk); #1;
        pulse(PE);
        @(negedge clk);
        chk("t5_drained", empty, 1'b1);
        @(posedge clk); #1;

        // stray body flit, grant while empty, reset mid-packet
        send(mk(TB, 4'd0, 4'd0, 8'h61));
        @(negedge clk);
        chk("t6_err", err_flit, 1'b1);
        chk("t6_discard", empty, 1'b1);
        @(posedge clk); #1;
        pulse(PS);
        @(negedge clk);
        chk("t6_err_sticky", err_flit, 1'b1);
        chk("t6_empty_grant", empty, 1'b1);
        @(posedge clk); #1;
        send(mk(TH, 4'd2, 4'd1, 8'h62));
        rx_data = mk(TB, 4'd0, 4'd0, 8'h63);
        RTS = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!DCTS && n < 40);
        chk("t6_pre_req", {req_n, req_e, req_w, req_s, req_l}, 5'b01000);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        RTS = 1'b0;
        @(negedge clk);
        chk("t6_rst_dcts", DCTS, 1'b0);
        chk("t6_rst_req", {req_n, req_e, req_w, req_s, req_l}, 5'b0);
        chk("t6_rst_empty", empty, 1'b1);
        chk("t6_rst_err", err_flit, 1'b0);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
